// File: rtl/prm_pkg.sv
// Shared types and constants for the pulse rate meter (FSM states, edge-count width, BCD limit).
// The optional debounce filter is selected with PRM_DEBOUNCE_EN in prm_edge_sync.
package prm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GATE  = 2'd1,
      LATCH = 2'd2
   } state_t;

   localparam int         EDGE_W     = 5;
   localparam logic [3:0] DIGIT_MAX  = 4'd9;
   localparam int         GATE_SHIFT = 10;

   // Clamp a window's edge count to a single BCD digit.
   function automatic logic [3:0] sat_digit(input logic [EDGE_W-1:0] n);
      return (n > EDGE_W'(DIGIT_MAX)) ? DIGIT_MAX : n[3:0];
   endfunction

endpackage

// File: rtl/prm_edge_sync.sv
// Synchroniser, optional debounce filter (`define PRM_DEBOUNCE_EN) and rising-edge detector
// for the asynchronous pulse pin; emits a one-cycle rise pulse.
module prm_edge_sync #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_in,
   output logic rise
);

   logic sync_1;
   logic sync_2;
   logic level;
   logic level_prev;

   if (DEB_CYCLES < 1) begin : g_deb_check
      $error("DEB_CYCLES must be at least 1");
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= sig_in;
         sync_2 <= sync_1;
      end
   end

`ifdef PRM_DEBOUNCE_EN
   localparam int DEB_W = $clog2(DEB_CYCLES + 1);

   logic [DEB_W-1:0] stable_cnt;

   // Counts consecutive samples that disagree with the filtered level; any agreeing sample restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level      <= 1'b0;
         stable_cnt <= '0;
      end else if (sync_2 == level) begin
         stable_cnt <= '0;
      end else if (stable_cnt == DEB_W'(DEB_CYCLES - 1)) begin
         level      <= sync_2;
         stable_cnt <= '0;
      end else begin
         stable_cnt <= stable_cnt + DEB_W'(1);
      end
   end
`else
   assign level = sync_2;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_prev <= 1'b0;
      end else begin
         level_prev <= level;
      end
   end

   assign rise = level & ~level_prev;

endmodule

// File: rtl/pulse_rate_meter.sv
// Gated pulse counter: counts sig_in rising edges over a programmable window and reports one
// saturated BCD digit plus overflow. Debounce on the input is enabled with PRM_DEBOUNCE_EN.
module pulse_rate_meter
   import prm_pkg::*;
#(
   parameter int               CNT_W      = 24,
   parameter logic [CNT_W-1:0] GATE_COUNT = CNT_W'(10_000_000),
   parameter int               DEB_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sig_in,
   input  logic       en,
   input  logic [7:0] gate_sel,
   output logic [3:0] digit,
   output logic       overflow,
   output logic       meas_valid,
   output logic       busy
);

   state_t             state;
   state_t             state_nxt;
   logic               rise;
   logic [CNT_W-1:0]   compare;
   logic [CNT_W-1:0]   compare_q;
   logic [CNT_W-1:0]   gate_cnt;
   logic [EDGE_W-1:0]  edge_cnt;

   prm_edge_sync #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_edge_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .sig_in (sig_in),
      .rise   (rise)
   );

   assign compare = (gate_sel == 8'd0) ? GATE_COUNT : (CNT_W'(gate_sel) << GATE_SHIFT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt  = state;
      busy       = 1'b0;
      meas_valid = 1'b0;
      case (state)
         IDLE: begin
            if (en) state_nxt = GATE;
         end
         GATE: begin
            busy = 1'b1;
            if (!en)                         state_nxt = IDLE;
            else if (gate_cnt == compare_q)  state_nxt = LATCH;
         end
         LATCH: begin
            busy       = 1'b1;
            meas_valid = 1'b1;
            state_nxt  = en ? GATE : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // An edge arriving during LATCH seeds the next window instead of being lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gate_cnt  <= '0;
         edge_cnt  <= '0;
         compare_q <= '0;
         digit     <= '0;
         overflow  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               gate_cnt <= '0;
               edge_cnt <= '0;
               if (en) compare_q <= compare;
            end
            GATE: begin
               if (!en) begin
                  gate_cnt <= '0;
                  edge_cnt <= '0;
               end else begin
                  if (rise && (edge_cnt != '1)) edge_cnt <= edge_cnt + EDGE_W'(1);
                  if (gate_cnt != compare_q)    gate_cnt <= gate_cnt + CNT_W'(1);
               end
            end
            LATCH: begin
               digit     <= sat_digit(edge_cnt);
               overflow  <= (edge_cnt > EDGE_W'(DIGIT_MAX));
               gate_cnt  <= '0;
               edge_cnt  <= rise ? EDGE_W'(1) : '0;
               compare_q <= compare;
            end
            default: begin
               gate_cnt <= '0;
               edge_cnt <= '0;
            end
         endcase
      end
   end

endmodule
